// File: rtl/screen_pkg.sv
// ---------------------------------------------------------------------------
// screen_pkg
//   Shared definitions for the maze screen sequencer:
//     - FSM state encoding (TITLE/PLAY/SCARE/END)
//     - screen_sel codes understood by the VGA mux
//     - foreground colour constants
//     - display record (screen_sel, fg_color, bg_white) and the per-state
//       display target decode
// ---------------------------------------------------------------------------
package screen_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_TITLE = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_SCARE = 2'd2;
  localparam logic [1:0] ST_END   = 2'd3;

  // screen_sel codes for the renderer mux
  localparam logic [1:0] SEL_TITLE = 2'd0;
  localparam logic [1:0] SEL_MAZE  = 2'd1;
  localparam logic [1:0] SEL_SCARE = 2'd2;
  localparam logic [1:0] SEL_END   = 2'd3;

  // RGB foreground colours
  localparam logic [2:0] COL_BLUE  = 3'b001;
  localparam logic [2:0] COL_RED   = 3'b100;
  localparam logic [2:0] COL_GREEN = 3'b010;
  localparam logic [2:0] COL_WHITE = 3'b111;

  typedef struct packed {
    logic [1:0] sel;
    logic [2:0] fg;
    logic       bg_white;
  } disp_t;

  localparam disp_t DISP_RESET = '{sel: SEL_TITLE, fg: COL_BLUE, bg_white: 1'b0};

  // What the screen should show for a given state. In SCARE the image
  // alternates between red-on-white and white-on-black with blink_phase.
  function automatic disp_t display_target(input logic [1:0] st,
                                           input logic       blink_phase);
    disp_t d;
    d = DISP_RESET;
    case (st)
      ST_TITLE: d = '{sel: SEL_TITLE, fg: COL_BLUE,  bg_white: 1'b0};
      ST_PLAY:  d = '{sel: SEL_MAZE,  fg: COL_BLUE,  bg_white: 1'b0};
      ST_SCARE: begin
        if (!blink_phase) d = '{sel: SEL_SCARE, fg: COL_RED,   bg_white: 1'b1};
        else              d = '{sel: SEL_SCARE, fg: COL_WHITE, bg_white: 1'b0};
      end
      ST_END:   d = '{sel: SEL_END,   fg: COL_GREEN, bg_white: 1'b0};
      default:  d = DISP_RESET;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/screen_sequencer_frame_counter.sv
// ---------------------------------------------------------------------------
// frame_counter
//   Counts frame_tick pulses. Cleared by clr_i (clear wins over tick).
//   On a tick with count == terminal_i the counter returns to 0.
//   Ports:
//     clk, reset    clock, asynchronous active-high reset
//     clr_i         synchronous clear (has priority over tick_i)
//     tick_i        count enable, one pulse per frame
//     terminal_i    last count value before wrapping to 0
//     count_o       current count
//     is_last_o     count_o == terminal_i
// ---------------------------------------------------------------------------
module frame_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] terminal_i,
  output logic [CNT_W-1:0] count_o,
  output logic             is_last_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign is_last_o = (count_q == terminal_i);
  assign count_o   = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (tick_i) begin
      count_d = is_last_o ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/screen_sequencer.sv
// ---------------------------------------------------------------------------
// screen_sequencer
//   Game-level controller for the maze video path. A 4-state FSM
//   (TITLE, PLAY, SCARE, END) picks the renderer feeding the VGA mux and
//   drives its foreground colour and background select. Display outputs are
//   shadow registers loaded only on frame_tick, so the picture never changes
//   mid-frame.
//   Ports:
//     clk, reset       clock, asynchronous active-high reset
//     frame_tick       1-cycle pulse at the start of each frame
//     start_btn        debounced start button (level, rising edge starts)
//     collision        player touched a wall (level, used in PLAY)
//     goal_reached     player reached the exit (level, used in PLAY)
//     screen_sel       0=title 1=maze 2=scare 3=end (frame aligned)
//     fg_color         RGB foreground colour (frame aligned)
//     bg_white         1=white image background (frame aligned)
//     player_reset     1-clk pulse when a game starts
//     dbg_state        current FSM state
//     dbg_frame_cnt    state-duration frame counter
//     dbg_blink_cnt    blink half-period frame counter
//     dbg_blink_phase  current SCARE blink phase
// ---------------------------------------------------------------------------
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int SCARE_FRAMES = 180,
  parameter int BLINK_FRAMES = 8,
  parameter int END_FRAMES   = 120,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             start_btn,
  input  logic             collision,
  input  logic             goal_reached,
  output logic [1:0]       screen_sel,
  output logic [2:0]       fg_color,
  output logic             bg_white,
  output logic             player_reset,
  output logic [1:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_frame_cnt,
  output logic [CNT_W-1:0] dbg_blink_cnt,
  output logic             dbg_blink_phase
);

  localparam logic [CNT_W-1:0] SCARE_LAST = CNT_W'(SCARE_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0] END_LAST   = CNT_W'(END_FRAMES - 1);

  logic [1:0] state_q, state_d;
  logic       btn_prev_q;
  logic       start_rise;
  logic       player_reset_q, player_reset_d;
  logic       blink_phase_q, blink_phase_d;
  disp_t      disp_q, disp_d, disp_tgt;

  logic             state_changed;
  logic             dur_clr, blink_clr;
  logic [CNT_W-1:0] dur_terminal;
  logic [CNT_W-1:0] dur_count, blink_count;
  logic             dur_last, blink_last;

  // Button held through reset must not start a game, hence btn_prev resets to 1.
  assign start_rise = start_btn & ~btn_prev_q;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    player_reset_d = 1'b0;
    case (state_q)
      ST_TITLE: begin
        if (start_rise) begin
          state_d        = ST_PLAY;
          player_reset_d = 1'b1;
        end
      end
      ST_PLAY: begin
        // Collision has priority over reaching the goal in the same cycle.
        if (collision)         state_d = ST_SCARE;
        else if (goal_reached) state_d = ST_END;
      end
      ST_SCARE, ST_END: begin
        if (frame_tick && dur_last) state_d = ST_TITLE;
      end
      default: state_d = ST_TITLE;
    endcase
  end

  assign state_changed = (state_d != state_q);

  // -------------------------------------------------------------------------
  // Frame counters. Clearing on the transition cycle means the frame_tick of
  // the entry cycle is not counted; counting starts with the next tick.
  // Outside SCARE/END both counters are held at zero.
  // -------------------------------------------------------------------------
  assign dur_terminal = (state_q == ST_END) ? END_LAST : SCARE_LAST;
  assign dur_clr      = ~((state_q == ST_SCARE) || (state_q == ST_END)) | state_changed;
  assign blink_clr    = (state_q != ST_SCARE) | state_changed;

  frame_counter #(.CNT_W(CNT_W)) u_dur_cnt (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (dur_clr),
    .tick_i     (frame_tick),
    .terminal_i (dur_terminal),
    .count_o    (dur_count),
    .is_last_o  (dur_last)
  );

  frame_counter #(.CNT_W(CNT_W)) u_blink_cnt (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (blink_clr),
    .tick_i     (frame_tick),
    .terminal_i (BLINK_LAST),
    .count_o    (blink_count),
    .is_last_o  (blink_last)
  );

  always_comb begin
    blink_phase_d = blink_phase_q;
    if (blink_clr) begin
      blink_phase_d = 1'b0;
    end else if (frame_tick && blink_last) begin
      blink_phase_d = ~blink_phase_q;
    end
  end

  // -------------------------------------------------------------------------
  // Frame-aligned shadow registers: loaded from the state held before the
  // tick edge, so a transition on a tick edge shows one frame later.
  // -------------------------------------------------------------------------
  assign disp_tgt = display_target(state_q, blink_phase_q);

  always_comb begin
    disp_d = disp_q;
    if (frame_tick) disp_d = disp_tgt;
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_TITLE;
      btn_prev_q     <= 1'b1;
      player_reset_q <= 1'b0;
      blink_phase_q  <= 1'b0;
      disp_q         <= DISP_RESET;
    end else begin
      state_q        <= state_d;
      btn_prev_q     <= start_btn;
      player_reset_q <= player_reset_d;
      blink_phase_q  <= blink_phase_d;
      disp_q         <= disp_d;
    end
  end

  assign screen_sel      = disp_q.sel;
  assign fg_color        = disp_q.fg;
  assign bg_white        = disp_q.bg_white;
  assign player_reset    = player_reset_q;
  assign dbg_state       = state_q;
  assign dbg_frame_cnt   = dur_count;
  assign dbg_blink_cnt   = blink_count;
  assign dbg_blink_phase = blink_phase_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// ---------------------------------------------------------------------------
// tb_screen_sequencer
//   Directed scenarios followed by a randomized run, checked every cycle
//   against a game-level reference model (modes, frames spent in a mode,
//   blink phase derived arithmetically from the frame count).
// ---------------------------------------------------------------------------
module tb_screen_sequencer;

  localparam int SCARE_FRAMES = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int END_FRAMES   = 3;
  localparam int CNT_W        = 8;
  localparam int TICK_PERIOD  = 10;

  // Mode numbers as the specification defines them
  localparam int M_TITLE = 0;
  localparam int M_PLAY  = 1;
  localparam int M_SCARE = 2;
  localparam int M_END   = 3;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, frame_tick, start_btn, collision, goal_reached;
  logic [1:0]       screen_sel;
  logic [2:0]       fg_color;
  logic             bg_white, player_reset;
  logic [1:0]       dbg_state;
  logic [CNT_W-1:0] dbg_frame_cnt, dbg_blink_cnt;
  logic             dbg_blink_phase;

  screen_sequencer #(
    .SCARE_FRAMES (SCARE_FRAMES),
    .BLINK_FRAMES (BLINK_FRAMES),
    .END_FRAMES   (END_FRAMES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .frame_tick      (frame_tick),
    .start_btn       (start_btn),
    .collision       (collision),
    .goal_reached    (goal_reached),
    .screen_sel      (screen_sel),
    .fg_color        (fg_color),
    .bg_white        (bg_white),
    .player_reset    (player_reset),
    .dbg_state       (dbg_state),
    .dbg_frame_cnt   (dbg_frame_cnt),
    .dbg_blink_cnt   (dbg_blink_cnt),
    .dbg_blink_phase (dbg_blink_phase)
  );

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  int         m_mode;
  int         m_frames;     // ticks counted since entering the mode
  logic       m_prev_btn;
  logic [1:0] m_sel;
  logic [2:0] m_fg;
  logic       m_bg;
  logic       m_pr;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  function automatic void model_reset();
    m_mode     = M_TITLE;
    m_frames   = 0;
    m_prev_btn = 1'b1;
    m_sel      = 2'd0;
    m_fg       = 3'b001;
    m_bg       = 1'b0;
    m_pr       = 1'b0;
  endfunction

  // One clock edge of the game rules, using the inputs present before the edge.
  function automatic void model_step();
    int nm;
    int nf;
    if (reset) begin
      model_reset();
      return;
    end
    if (frame_tick) begin
      case (m_mode)
        M_TITLE: begin m_sel = 2'd0; m_fg = 3'b001; m_bg = 1'b0; end
        M_PLAY:  begin m_sel = 2'd1; m_fg = 3'b001; m_bg = 1'b0; end
        M_SCARE: begin
          m_sel = 2'd2;
          if (((m_frames / BLINK_FRAMES) % 2) == 0) begin m_fg = 3'b100; m_bg = 1'b1; end
          else                                      begin m_fg = 3'b111; m_bg = 1'b0; end
        end
        default: begin m_sel = 2'd3; m_fg = 3'b010; m_bg = 1'b0; end
      endcase
    end
    nm   = m_mode;
    nf   = m_frames;
    m_pr = 1'b0;
    case (m_mode)
      M_TITLE: if (start_btn && !m_prev_btn) begin nm = M_PLAY; m_pr = 1'b1; end
      M_PLAY: begin
        if (collision)         nm = M_SCARE;
        else if (goal_reached) nm = M_END;
      end
      M_SCARE: if (frame_tick) begin
        if (m_frames + 1 == SCARE_FRAMES) nm = M_TITLE;
        else                              nf = m_frames + 1;
      end
      default: if (frame_tick) begin
        if (m_frames + 1 == END_FRAMES) nm = M_TITLE;
        else                            nf = m_frames + 1;
      end
    endcase
    if (nm != m_mode) nf = 0;
    m_mode     = nm;
    m_frames   = nf;
    m_prev_btn = start_btn;
  endfunction

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int exp_blink;
    int exp_phase;
    exp_blink = (m_mode == M_SCARE) ? (m_frames % BLINK_FRAMES) : 0;
    exp_phase = (m_mode == M_SCARE) ? ((m_frames / BLINK_FRAMES) % 2) : 0;
    chk({tag, ".sel"},   8'(screen_sel),      8'(m_sel));
    chk({tag, ".fg"},    8'(fg_color),        8'(m_fg));
    chk({tag, ".bg"},    8'(bg_white),        8'(m_bg));
    chk({tag, ".pr"},    8'(player_reset),    8'(m_pr));
    chk({tag, ".state"}, 8'(dbg_state),       8'(m_mode));
    chk({tag, ".fcnt"},  8'(dbg_frame_cnt),   8'(m_frames));
    chk({tag, ".bcnt"},  8'(dbg_blink_cnt),   8'(exp_blink));
    chk({tag, ".phase"}, 8'(dbg_blink_phase), 8'(exp_phase));
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  // Advance one clock; model follows the edge, outputs checked on the falling
  // edge, then frame_tick is set up for the next edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model("mdl");
    cyc++;
    frame_tick = ((cyc % TICK_PERIOD) == 0);
  endtask

  // Run until one frame_tick edge has been applied.
  task automatic run_to_tick();
    logic t;
    for (int i = 0; i < 2 * TICK_PERIOD; i++) begin
      t = frame_tick;
      cycle();
      if (t) return;
    end
    chk("tick_timeout", 8'd1, 8'd0);
  endtask

  // Make sure the next edge is not a frame_tick edge.
  task automatic avoid_tick();
    if (frame_tick) cycle();
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    reset        = 1'b1;
    start_btn    = 1'b1;
    collision    = 1'b0;
    goal_reached = 1'b0;
    frame_tick   = 1'b0;
    model_reset();

    // Reset values, button held through reset
    @(negedge clk);
    chk("rst_sel",   8'(screen_sel),   8'd0);
    chk("rst_fg",    8'(fg_color),     8'h1);
    chk("rst_bg",    8'(bg_white),     8'd0);
    chk("rst_pr",    8'(player_reset), 8'd0);
    chk("rst_state", 8'(dbg_state),    8'd0);
    repeat (3) cycle();
    reset = 1'b0;
    repeat (25) cycle();
    chk("held_btn_stays_title", 8'(dbg_state), 8'd0);

    // Release and press: game starts
    start_btn = 1'b0;
    repeat (3) cycle();
    avoid_tick();
    start_btn = 1'b1;
    cycle();
    chk("start_state_play", 8'(dbg_state),    8'd1);
    chk("start_pr_high",    8'(player_reset), 8'd1);
    chk("start_sel_old",    8'(screen_sel),   8'd0);
    cycle();
    chk("start_pr_low",     8'(player_reset), 8'd0);
    start_btn = 1'b0;
    run_to_tick();
    chk("play_sel",         8'(screen_sel),   8'd1);

    // Collision and goal together: collision wins
    avoid_tick();
    collision    = 1'b1;
    goal_reached = 1'b1;
    cycle();
    collision    = 1'b0;
    goal_reached = 1'b0;
    chk("both_to_scare",  8'(dbg_state),  8'd2);
    chk("scare_sel_old",  8'(screen_sel), 8'd1);
    run_to_tick();
    chk("scare_f1_sel",   8'(screen_sel), 8'd2);
    chk("scare_f1_fg",    8'(fg_color),   8'h4);
    chk("scare_f1_bg",    8'(bg_white),   8'd1);
    run_to_tick();
    chk("scare_f2_fg",    8'(fg_color),   8'h4);
    chk("scare_f2_bg",    8'(bg_white),   8'd1);
    start_btn = 1'b1;
    cycle();
    start_btn = 1'b0;
    cycle();
    chk("scare_btn_ignored", 8'(dbg_state), 8'd2);
    run_to_tick();
    chk("scare_f3_fg",    8'(fg_color),   8'h7);
    chk("scare_f3_bg",    8'(bg_white),   8'd0);
    run_to_tick();
    chk("scare_f4_fg",    8'(fg_color),   8'h7);
    chk("scare_exit",     8'(dbg_state),  8'd0);
    chk("scare_exit_sel", 8'(screen_sel), 8'd2);
    run_to_tick();
    chk("title_sel",      8'(screen_sel), 8'd0);
    chk("title_fg",       8'(fg_color),   8'h1);

    // Goal reached: END screen for 3 counted frames
    avoid_tick();
    start_btn = 1'b1;
    cycle();
    start_btn = 1'b0;
    cycle();
    avoid_tick();
    goal_reached = 1'b1;
    cycle();
    goal_reached = 1'b0;
    chk("goal_to_end",    8'(dbg_state),  8'd3);
    run_to_tick();
    chk("end_sel",        8'(screen_sel), 8'd3);
    chk("end_fg",         8'(fg_color),   8'h2);
    chk("end_bg",         8'(bg_white),   8'd0);
    run_to_tick();
    run_to_tick();
    chk("end_exit",       8'(dbg_state),  8'd0);
    chk("end_exit_sel",   8'(screen_sel), 8'd3);
    run_to_tick();
    chk("end_title_sel",  8'(screen_sel), 8'd0);

    // State change on the same edge as frame_tick
    for (int i = 0; i < TICK_PERIOD && !frame_tick; i++) cycle();
    chk("tick_pending", 8'(frame_tick), 8'd1);
    start_btn = 1'b1;
    cycle();
    start_btn = 1'b0;
    chk("same_edge_state", 8'(dbg_state),  8'd1);
    chk("same_edge_sel",   8'(screen_sel), 8'd0);
    run_to_tick();
    chk("same_edge_next",  8'(screen_sel), 8'd1);

    // Reset during SCARE frame 2
    avoid_tick();
    collision = 1'b1;
    cycle();
    collision = 1'b0;
    run_to_tick();
    run_to_tick();
    repeat (3) cycle();
    chk("pre_rst_sel", 8'(screen_sel), 8'd2);
    reset = 1'b1;
    #1;
    chk("mid_rst_sel",   8'(screen_sel),   8'd0);
    chk("mid_rst_fg",    8'(fg_color),     8'h1);
    chk("mid_rst_bg",    8'(bg_white),     8'd0);
    chk("mid_rst_state", 8'(dbg_state),    8'd0);
    chk("mid_rst_pr",    8'(player_reset), 8'd0);
    model_reset();
    cycle();
    reset = 1'b0;
    repeat (5) cycle();

    // Randomized play
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) start_btn = ~start_btn;
      collision    = ($urandom_range(0, 29) == 0);
      goal_reached = ($urandom_range(0, 19) == 0);
      reset        = ($urandom_range(0, 499) == 0);
      cycle();
    end
    reset = 1'b0;
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
